fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag controller for the team's dual-clock DMA FIFOs.
- Runs entirely in the write clock domain:
  - accepts pushes with a valid/ready handshake;
  - drives the RAM write address and enable;
  - publishes a registered Gray-coded write pointer, which feeds the vector synchronizer into the read domain.
- Consumes the read pointer after that synchronizer has brought it into this domain, and derives full, almost-full and fill level from it.

Parameters:
- ADDR_WIDTH, 4, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH (16 by default).
- AFULL_THRESH, 12, almost_full asserts when wlevel >= this value. Legal range is 1..DEPTH.

Ports:
- CLK  in  1  write-domain clock.
- RST  in  1  synchronous, active-high reset.
- push_valid  in  1  producer has a word to write.
- push_ready  out  1  FIFO can accept a word this cycle.
- wen  out  1  RAM write enable.
- waddr  out  ADDR_WIDTH  RAM write address.
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the synchronizer.
- rptr_gray_sync  in  ADDR_WIDTH+1  read pointer in Gray code, already synchronized into CLK.
- full  out  1  FIFO full.
- almost_full  out  1  wlevel >= AFULL_THRESH.
- wlevel  out  ADDR_WIDTH+1  conservative fill level, range 0..DEPTH.
- ptr_err  out  1  sticky flag: pointer-crossing corruption detected.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, on ports CLK and RST.
- Reset (RST high at a CLK edge): wbin, wptr_gray, full, almost_full, wlevel and ptr_err all go to 0.
- push_ready = ~full & ~RST. It is therefore 0 while RST is high, and 1 in the first cycle after reset.
- wen = push_valid & push_ready (combinational).
- waddr = wbin[ADDR_WIDTH-1:0] (combinational from the flop).
- State register wbin, width ADDR_WIDTH+1; the extra MSB is the wrap bit.
- wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - Wrap-around from all-ones to 0 is silent.
- wptr_gray is registered: wptr_gray <= bin2gray(wbin_next).
  - It must come straight from a flop with no combinational logic after it, because it crosses clock domains.
  - Exactly one bit changes per increment.
- rbin_sync = gray2bin(rptr_gray_sync), combinational.
- level_next = (wbin_next - rbin_sync) modulo 2**(ADDR_WIDTH+1).
- Registered outputs, all updated at the same edge:
  - full <= (bin2gray(wbin_next) == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}).
  - wlevel <= level_next, saturated at DEPTH.
  - almost_full <= (level_next >= AFULL_THRESH).
- Latency:
  - full, wlevel and almost_full reflect a push in the cycle after wen. This means a push can never overflow.
  - A change on rptr_gray_sync is reflected 1 cycle later. full can therefore deassert late, never early, which is safe.
- Simultaneous events: a push and a read-pointer advance in the same cycle are both folded into level_next, so the level is net unchanged.
- ptr_err is set when level_next > DEPTH, i.e. the synchronized read pointer is ahead of the write pointer.
  - It stays set until RST.
  - Normal operation continues; the level is clamped to DEPTH.
- Reset mid-operation: all state clears in the cycle RST is sampled. Clearing the read-side partner is the system's responsibility.
- No state machine beyond the pointer counter. push_valid may drop without the push completing; no stalls are retained.

Decomposition:
- Shared package fifo_ptr_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width through a ADDR_WIDTH+1 localparam pattern;
  - the DEPTH derivation.
- These are reused by the future read-side fifo_rptr_empty.
- No sub-module: the block is one counter plus comparators. The synchronizer is instantiated by the FIFO top, not inside this block.

Test Plan:
- Reset and idle:
  - Stimulus: hold RST 3 cycles with push_valid=1, then release, with rptr_gray_sync=0.
  - Required response: push_ready=0 and wen=0 during reset; all outputs 0. push_ready=1 in the first cycle after release.
- Fill to full:
  - Stimulus: 16 back-to-back pushes with rptr_gray_sync=0.
  - Required response: waddr 0..15; wptr_gray sequence 0x01, 0x03, 0x02, 0x06...; almost_full rises the cycle after the 12th push. After the 16th push: full=1, wlevel=16, wptr_gray=0x18, push_ready=0.
  - A 17th push_valid must produce no wen.
- Drain and refill across wrap:
  - Stimulus: from full, set rptr_gray_sync=bin2gray(16)=0x18, then push 16 more, then set rptr_gray_sync=0x00 (bin 32 mod 32).
  - Required response: full deasserts 1 cycle after the 0x18 change. wbin wraps 31 -> 0 with full re-asserting at the 32nd total push. Final wlevel=0.
- Simultaneous push and read:
  - Stimulus: wlevel=5; push while rptr advances by 1 in the same cycle.
  - Required response: wlevel stays 5 and almost_full is unchanged.
- Corrupt crossing:
  - Stimulus: wbin=2, force rptr_gray_sync=bin2gray(5)=0x07.
  - Required response: ptr_err=1 next cycle, wlevel clamped to 16, full=0. ptr_err holds after rptr is restored and clears only on RST.
- Reset mid-fill:
  - Stimulus: after 9 pushes, pulse RST 1 cycle.
  - Required response: next cycle wptr_gray=0, waddr=0, wlevel=0, almost_full=0, ptr_err=0.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO write and read pointer controllers.
// Functions work on a wide pointer type; callers zero-extend in and truncate out to ADDR_WIDTH+1.
package fifo_ptr_pkg;

  localparam int MAX_PTR_W = 16;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input yields the correct binary value in the low bits.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/level controller for dual-clock FIFOs.
// wptr_gray leaves this block straight from a flop so it can cross clock domains safely.
module fifo_wptr_full
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push_valid,
  output logic                  push_ready,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  ptr_err
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P = ptr_t'(AFULL_THRESH);

  function automatic ptr_t to_gray(input ptr_t b);
    return ptr_t'(bin2gray(ptr_max_t'(b)));
  endfunction

  function automatic ptr_t to_bin(input ptr_t g);
    return ptr_t'(gray2bin(ptr_max_t'(g)));
  endfunction

  // A read pointer ahead of the write pointer shows up as a level above DEPTH.
  function automatic ptr_t sat_level(input ptr_t lvl);
    return (lvl > DEPTH_P) ? DEPTH_P : lvl;
  endfunction

  ptr_t wbin_p0;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t rbin_sync;
  ptr_t level_next;
  ptr_t rgray_full;
  logic full_next;

  assign push_ready = ~full & ~RST;
  assign wen        = push_valid & push_ready;
  assign waddr      = wbin_p0[ADDR_WIDTH-1:0];

  assign wbin_next  = wbin_p0 + ptr_t'(wen);
  assign wgray_next = to_gray(wbin_next);
  assign rbin_sync  = to_bin(rptr_gray_sync);
  assign level_next = wbin_next - rbin_sync;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rgray_full = {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
  assign full_next  = (wgray_next == rgray_full);

  // Stage p0: pointer counter and all status flags update together
  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin_p0     <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      ptr_err     <= 1'b0;
    end else begin
      wbin_p0     <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= (level_next >= AFULL_P);
      wlevel      <= sat_level(level_next);
      if (level_next > DEPTH_P) begin
        ptr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed vector bench for fifo_wptr_full with hand-computed expectations.
module tb_fifo_wptr_full;

  logic       CLK;
  logic       RST;
  logic       push_valid;
  logic       push_ready;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_gray_sync;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       ptr_err;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .wen           (wen),
    .waddr         (waddr),
    .wptr_gray     (wptr_gray),
    .rptr_gray_sync(rptr_gray_sync),
    .full          (full),
    .almost_full   (almost_full),
    .wlevel        (wlevel),
    .ptr_err       (ptr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Gray code of binary 0..31
  logic [4:0] G [32] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                         5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
                         5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
                         5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10};

  // Inputs held for one edge; pr/wen/waddr seen before the edge, the rest after it.
  typedef struct {
    logic       rst;
    logic       pv;
    logic [4:0] rg;
    logic       pr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic pv, input logic [4:0] rg,
                     input logic pr, input logic w, input logic [3:0] wa,
                     input logic [4:0] gray, input logic f, input logic af,
                     input logic [4:0] lvl, input logic err);
    vec_t v;
    v.rst = rst; v.pv = pv; v.rg = rg; v.pr = pr; v.wen = w; v.waddr = wa;
    v.gray = gray; v.full = f; v.af = af; v.lvl = lvl; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge CLK);
    RST = v.rst;
    push_valid = v.pv;
    rptr_gray_sync = v.rg;
    #1;
    chk("push_ready", idx, 32'(push_ready), 32'(v.pr));
    chk("wen", idx, 32'(wen), 32'(v.wen));
    if (!v.rst) chk("waddr", idx, 32'(waddr), 32'(v.waddr));
    @(posedge CLK);
    #1;
    chk("wptr_gray", idx, 32'(wptr_gray), 32'(v.gray));
    chk("full", idx, 32'(full), 32'(v.full));
    chk("almost_full", idx, 32'(almost_full), 32'(v.af));
    chk("wlevel", idx, 32'(wlevel), 32'(v.lvl));
    chk("ptr_err", idx, 32'(ptr_err), 32'(v.err));
  endtask

  initial begin
    RST = 1'b1;
    push_valid = 1'b0;
    rptr_gray_sync = 5'h00;

    // Reset held 3 cycles with push_valid high, then first idle cycle
    for (int i = 0; i < 3; i++) add(1, 1, 5'h00, 0, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    add(0, 0, 5'h00, 1, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    // Fill to full
    for (int i = 0; i < 16; i++)
      add(0, 1, 5'h00, 1, 1, 4'(i), G[i+1], (i == 15), (i >= 11), 5'(i + 1), 0);
    // 17th push refused
    add(0, 1, 5'h00, 0, 0, 4'd0, 5'h18, 1, 1, 5'd16, 0);
    // Drain: read pointer jumps to 16
    add(0, 0, 5'h18, 0, 0, 4'd0, 5'h18, 0, 0, 5'd0, 0);
    // Refill across the wrap, 16 more pushes
    for (int j = 0; j < 16; j++)
      add(0, 1, 5'h18, 1, 1, 4'(j), G[(17 + j) % 32], (j == 15), (j >= 11), 5'(j + 1), 0);
    // Read pointer reaches 32 mod 32
    add(0, 0, 5'h00, 0, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    // Build level 5, then push and read together
    for (int k = 0; k < 5; k++)
      add(0, 1, 5'h00, 1, 1, 4'(k), G[k+1], 0, 0, 5'(k + 1), 0);
    add(0, 1, G[1], 1, 1, 4'd5, G[6], 0, 0, 5'd5, 0);
    // Corrupt crossing: wbin=2, rptr=bin 5
    add(1, 0, 5'h00, 0, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    add(0, 1, 5'h00, 1, 1, 4'd0, 5'h01, 0, 0, 5'd1, 0);
    add(0, 1, 5'h00, 1, 1, 4'd1, 5'h03, 0, 0, 5'd2, 0);
    add(0, 0, 5'h07, 1, 0, 4'd2, 5'h03, 0, 1, 5'd16, 1);
    add(0, 0, 5'h00, 1, 0, 4'd2, 5'h03, 0, 0, 5'd2, 1);
    add(0, 0, 5'h00, 1, 0, 4'd2, 5'h03, 0, 0, 5'd2, 1);
    // Reset mid-fill after 9 pushes
    add(1, 0, 5'h00, 0, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    for (int i = 0; i < 9; i++)
      add(0, 1, 5'h00, 1, 1, 4'(i), G[i+1], 0, 0, 5'(i + 1), 0);
    add(1, 1, 5'h00, 0, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);
    add(0, 0, 5'h00, 1, 0, 4'd0, 5'h00, 0, 0, 5'd0, 0);

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);

    // Hand sequence: simultaneous push and read while almost full
    begin
      vec_t v;
      for (int i = 0; i < 12; i++) begin
        v = '{0, 1, 5'h00, 1, 1, 4'(i), G[i+1], 0, (i >= 11), 5'(i + 1), 0};
        run_vec(v, 100 + i);
      end
      v = '{0, 1, G[1], 1, 1, 4'd12, G[13], 0, 1, 5'd12, 0};
      run_vec(v, 200);
      v = '{0, 0, G[2], 1, 0, 4'd13, G[13], 0, 0, 5'd11, 0};
      run_vec(v, 201);
      // push_valid dropped: no write, nothing retained
      v = '{0, 0, G[2], 1, 0, 4'd13, G[13], 0, 0, 5'd11, 0};
      run_vec(v, 202);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
